// File: rtl/task_answer_packetizer.sv
// task_answer_packetizer: buffers one task answer and emits it as a checksummed byte frame
module task_answer_packetizer #(
   parameter logic [7:0] TASK_ID    = 8'h02,
   parameter logic [7:0] SYNC_BYTE  = 8'hA5,
   parameter int         FIFO_DEPTH = 256
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_answer_valid,
   input  logic [31:0] i_answer_data,
   input  logic        i_answer_last,
   input  logic [31:0] i_answer_size_in_bytes,
   input  logic [31:0] i_answer_latency,
   output logic [7:0]  o_tx_data,
   output logic        o_tx_valid,
   input  logic        i_tx_ready,
   output logic        o_busy,
   output logic        o_overflow,
   output logic        o_underrun
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_SYNC    = 3'd1;
   localparam logic [2:0] S_ID      = 3'd2;
   localparam logic [2:0] S_SIZE    = 3'd3;
   localparam logic [2:0] S_LAT     = 3'd4;
   localparam logic [2:0] S_PAYLOAD = 3'd5;
   localparam logic [2:0] S_CSUM    = 3'd6;

   logic [31:0] mem [FIFO_DEPTH];
   logic [AW:0] wr_ptr, rd_ptr;
   logic [31:0] size_q, lat_q, cnt, head;
   logic [2:0]  state;
   logic [1:0]  idx;
   logic [7:0]  csum, head_byte;
   logic        pending, zhold, empty, full, push, pop, xfer, byte_empty, last_in;

   assign empty      = wr_ptr == rd_ptr;
   assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign push       = i_answer_valid && !full;
   assign last_in    = i_answer_valid && i_answer_last;
   assign xfer       = o_tx_valid && i_tx_ready;
   // once a payload byte has been shown as an underrun zero it stays zero until taken
   assign byte_empty = empty || zhold;
   assign pop        = xfer && state == S_PAYLOAD && !byte_empty && (idx == 2'd3 || cnt == 32'd1);
   assign head       = mem[rd_ptr[AW-1:0]];
   assign head_byte  = head[{idx, 3'b000} +: 8];
   assign o_tx_valid = state != S_IDLE;
   assign o_busy     = state != S_IDLE;
   assign o_tx_data  = state == S_SYNC    ? SYNC_BYTE :
                       state == S_ID      ? TASK_ID :
                       state == S_SIZE    ? size_q[{idx, 3'b000} +: 8] :
                       state == S_LAT     ? lat_q[{idx, 3'b000} +: 8] :
                       state == S_PAYLOAD ? (byte_empty ? 8'h00 : head_byte) :
                       state == S_CSUM    ? csum : 8'h00;

   // answer word storage
   always_ff @(posedge i_clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= i_answer_data;
   end

   // FIFO pointers; push and pop may happen together
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // header latch, pending flag and sticky error flags
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         pending    <= 1'b0;
         size_q     <= '0;
         lat_q      <= '0;
         o_overflow <= 1'b0;
         o_underrun <= 1'b0;
      end else begin
         if (last_in && !pending) begin
            size_q <= i_answer_size_in_bytes;
            lat_q  <= i_answer_latency;
         end
         pending    <= (pending && !(xfer && state == S_CSUM)) || (last_in && !pending);
         o_overflow <= o_overflow || (i_answer_valid && full) || (last_in && pending);
         o_underrun <= o_underrun || (xfer && state == S_PAYLOAD && byte_empty);
      end
   end

   // holds an underrun zero byte stable while the transmitter stalls
   always_ff @(posedge i_clk) begin
      if (i_rst) zhold <= 1'b0;
      else zhold <= state == S_PAYLOAD && byte_empty && !xfer;
   end

   // frame sequencer with byte index, payload countdown and checksum
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= S_IDLE;
         idx   <= 2'd0;
         cnt   <= '0;
         csum  <= 8'd0;
      end else if (state == S_IDLE) begin
         csum <= 8'd0;
         idx  <= 2'd0;
         if (pending) state <= S_SYNC;
      end else if (xfer) begin
         if (state != S_SYNC && state != S_CSUM) csum <= csum + o_tx_data;
         if (state == S_SIZE || state == S_LAT || state == S_PAYLOAD) idx <= idx + 2'd1;
         case (state)
            S_SYNC: state <= S_ID;
            S_ID: state <= S_SIZE;
            S_SIZE: if (idx == 2'd3) state <= S_LAT;
            S_LAT: if (idx == 2'd3) begin
               cnt   <= size_q;
               state <= size_q == 32'd0 ? S_CSUM : S_PAYLOAD;
            end
            S_PAYLOAD: begin
               cnt <= cnt - 32'd1;
               if (cnt == 32'd1) state <= S_CSUM;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_task_answer_packetizer.sv
// tb_task_answer_packetizer: scoreboard bench for the answer packetizer
module tb_task_answer_packetizer;
   localparam int DEPTH = 256;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        a_valid = 1'b0;
   logic [31:0] a_data = '0;
   logic        a_last = 1'b0;
   logic [31:0] a_size = '0;
   logic [31:0] a_lat = '0;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b1;
   logic        busy, overflow, underrun;

   int n_cmp = 0;
   int n_bad = 0;
   logic [7:0]  exp_q [$];
   logic [31:0] mq [$];
   logic        stalled_prev = 1'b0;
   logic [7:0]  held = 8'h00;

   task_answer_packetizer #(.TASK_ID(8'h02), .SYNC_BYTE(8'hA5), .FIFO_DEPTH(DEPTH)) dut (
      .i_clk(clk),
      .i_rst(rst),
      .i_answer_valid(a_valid),
      .i_answer_data(a_data),
      .i_answer_last(a_last),
      .i_answer_size_in_bytes(a_size),
      .i_answer_latency(a_lat),
      .o_tx_data(tx_data),
      .o_tx_valid(tx_valid),
      .i_tx_ready(tx_ready),
      .o_busy(busy),
      .o_overflow(overflow),
      .o_underrun(underrun)
   );

   always #5 clk = ~clk;

   // scoreboard: every transferred byte is popped and compared; stalled bytes must hold
   always @(negedge clk) begin
      if (rst) stalled_prev = 1'b0;
      else begin
         if (stalled_prev) begin
            n_cmp++;
            if (!tx_valid || tx_data !== held) begin
               n_bad++;
               $display("FAIL stall_hold: valid=%0b data=%02h required valid=1 data=%02h", tx_valid, tx_data, held);
            end
         end
         if (tx_valid && tx_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_byte: got %02h with nothing expected", tx_data);
            end else begin
               logic [7:0] e;
               e = exp_q.pop_front();
               if (tx_data !== e) begin
                  n_bad++;
                  $display("FAIL frame_byte: got %02h required %02h", tx_data, e);
               end
            end
         end
         stalled_prev = tx_valid && !tx_ready;
         held = tx_data;
      end
   end

   task automatic push_word(input logic [31:0] d, input logic last, input logic [31:0] sz, input logic [31:0] lt);
      a_valid = 1'b1; a_data = d; a_last = last; a_size = sz; a_lat = lt;
      if (mq.size() < DEPTH) mq.push_back(d);
      @(posedge clk); #1;
      a_valid = 1'b0; a_last = 1'b0;
   endtask

   task automatic model_frame(input logic [31:0] sz, input logic [31:0] lt);
      logic [7:0] b, cs;
      logic [31:0] w;
      int k;
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h02);
      cs = 8'h02;
      for (int i = 0; i < 4; i++) begin b = sz[8*i +: 8]; exp_q.push_back(b); cs += b; end
      for (int i = 0; i < 4; i++) begin b = lt[8*i +: 8]; exp_q.push_back(b); cs += b; end
      for (longint i = 0; i < longint'(sz); i++) begin
         k = int'(i % 4);
         if (mq.size() == 0) b = 8'h00;
         else begin
            w = mq[0];
            b = w[8*k +: 8];
            if (k == 3 || i == longint'(sz) - 1) void'(mq.pop_front());
         end
         exp_q.push_back(b);
         cs += b;
      end
      exp_q.push_back(cs);
   endtask

   task automatic push_test1_bytes();
      logic [7:0] lit [19] = '{8'hA5, 8'h02, 8'h08, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00,
                               8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h3E};
      foreach (lit[i]) exp_q.push_back(lit[i]);
   endtask

   task automatic wait_drain(input int budget, input string name);
      bit done = 1'b0;
      for (int i = 0; i < budget && !done; i++) begin
         if (exp_q.size() == 0 && !busy) done = 1'b1;
         else begin @(posedge clk); #1; end
      end
      n_cmp++;
      if (!done) begin
         n_bad++;
         $display("FAIL %s_timeout: %0d bytes still expected busy=%0b", name, exp_q.size(), busy);
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %0b required 0", tx_valid); end
      n_cmp++; if (tx_data !== 8'h00) begin n_bad++; $display("FAIL rst_data: got %02h required 00", tx_data); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %0b required 0", busy); end
      n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL rst_overflow: got %0b required 0", overflow); end
      n_cmp++; if (underrun !== 1'b0) begin n_bad++; $display("FAIL rst_underrun: got %0b required 0", underrun); end
      rst = 1'b0;
      exp_q.delete();
      mq.delete();
   endtask

   task automatic test_basic();
      tx_ready = 1'b1;
      push_test1_bytes();
      push_word(32'h04030201, 1'b0, 32'd0, 32'd0);
      push_word(32'h08070605, 1'b1, 32'd8, 32'h10);
      void'(mq.pop_front());
      void'(mq.pop_front());
      n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL latency_idle: valid=%0b required 0", tx_valid); end
      @(posedge clk); #1;
      n_cmp++;
      if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin
         n_bad++;
         $display("FAIL latency_sync: valid=%0b data=%02h required 1 A5", tx_valid, tx_data);
      end
      wait_drain(100, "basic");
      n_cmp++; if (tx_data !== 8'h00) begin n_bad++; $display("FAIL idle_data: got %02h required 00", tx_data); end
      n_cmp++;
      if (overflow !== 1'b0 || underrun !== 1'b0) begin
         n_bad++;
         $display("FAIL basic_flags: ovf=%0b unr=%0b required 0 0", overflow, underrun);
      end
   endtask

   task automatic test_single();
      push_word(32'hDDCCBBAA, 1'b1, 32'd3, 32'd5);
      model_frame(32'd3, 32'd5);
      wait_drain(100, "single");
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_busy: got %0b required 0", busy); end
   endtask

   task automatic test_stall();
      int n = 0;
      push_test1_bytes();
      push_word(32'h04030201, 1'b0, 32'd0, 32'd0);
      push_word(32'h08070605, 1'b1, 32'd8, 32'h10);
      void'(mq.pop_front());
      void'(mq.pop_front());
      while ((exp_q.size() != 0 || busy) && n < 300) begin
         tx_ready = (n % 3) == 0;
         n++;
         @(posedge clk); #1;
      end
      tx_ready = 1'b1;
      wait_drain(10, "stall");
   endtask

   task automatic test_size0();
      push_word(32'h11223344, 1'b1, 32'd0, 32'h01020304);
      model_frame(32'd0, 32'h01020304);
      wait_drain(100, "size0");
      push_word(32'h55667788, 1'b1, 32'd8, 32'd0);
      model_frame(32'd8, 32'd0);
      wait_drain(100, "leftover");
      n_cmp++; if (underrun !== 1'b0) begin n_bad++; $display("FAIL size0_underrun: got %0b required 0", underrun); end
   endtask

   task automatic test_reset_mid();
      int n = 0;
      push_word(32'h0BADBEEF, 1'b1, 32'd4, 32'h99);
      model_frame(32'd4, 32'h99);
      while (exp_q.size() > 8 && n < 50) begin n++; @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL abort_valid: got %0b required 0", tx_valid); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %0b required 0", busy); end
      rst = 1'b0;
      exp_q.delete();
      mq.delete();
      push_word(32'hCAFEF00D, 1'b1, 32'd4, 32'd7);
      model_frame(32'd4, 32'd7);
      wait_drain(100, "after_abort");
   endtask

   task automatic test_overflow();
      test_reset();
      for (int i = 0; i <= DEPTH; i++) push_word($urandom, 1'b0, 32'd0, 32'd0);
      n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_set: got %0b required 1", overflow); end
      n_cmp++; if (underrun !== 1'b0) begin n_bad++; $display("FAIL ovf_underrun: got %0b required 0", underrun); end
      push_word(32'hFFFFFFFF, 1'b1, 32'(4 * DEPTH + 4), 32'h42);
      model_frame(32'(4 * DEPTH + 4), 32'h42);
      wait_drain(3000, "overflow");
      n_cmp++; if (underrun !== 1'b1) begin n_bad++; $display("FAIL underrun_set: got %0b required 1", underrun); end
      n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got %0b required 1", overflow); end
   endtask

   initial begin
      @(posedge clk); #1;
      test_reset();
      test_basic();
      test_single();
      test_stall();
      test_size0();
      test_reset_mid();
      test_overflow();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
